// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control-signal pipeline.
//   CTRL_CW             width of the decoded control bundle
//   *_BIT / ALUCONTROL_* bit positions of each field inside the bundle
//   KILL_MASK_REGWRITE  squash mask clearing only the register-file write enable
//   KILL_MASK_DEFAULT   squash mask clearing every architectural write enable
//                       (regwrite, memwrite, hilowrite, cp0write)
package ctrl_pkg;

    localparam int CTRL_CW = 16;

    localparam int ALUCONTROL_LSB = 0;
    localparam int ALUCONTROL_MSB = 4;
    localparam int MEMTOREG_BIT   = 5;
    localparam int MEMWRITE_BIT   = 6;
    localparam int ALUSRC_BIT     = 7;
    localparam int REGDST_BIT     = 8;
    localparam int JAL_BIT        = 9;
    localparam int JR_BIT         = 10;
    localparam int REGWRITE_BIT   = 11;
    localparam int BAL_BIT        = 12;
    localparam int MEMEN_BIT      = 13;
    localparam int HILOWRITE_BIT  = 14;
    localparam int CP0WRITE_BIT   = 15;

    // Overflow-style squash: the instruction still retires but must not
    // update the register file.
    localparam logic [CTRL_CW-1:0] KILL_MASK_REGWRITE = CTRL_CW'(1) << REGWRITE_BIT;

    // Precise-exception squash: suppress every architectural side effect.
    localparam logic [CTRL_CW-1:0] KILL_MASK_DEFAULT =
        (CTRL_CW'(1) << REGWRITE_BIT)  |
        (CTRL_CW'(1) << MEMWRITE_BIT)  |
        (CTRL_CW'(1) << HILOWRITE_BIT) |
        (CTRL_CW'(1) << CP0WRITE_BIT);

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: bundle of all decode-side and pipeline-side signals of ctrl_pipe.
//   ctrl_d/valid_d  decoded bundle entering stage 0 (master drives)
//   ready_d         stage 0 accepts the bundle this cycle (slave drives)
//   stall/flush     per-stage hold and clear requests, bit k = stage k
//   exc             squash request for the bundle leaving EXC_STAGE
//   ctrl_q/valid_q  per-stage bundle and valid, stage k at ctrl_q[k*CW +: CW]
//   bubble_cnt      saturating count of empty writeback cycles
interface ctrl_pipe_if
    import ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int CW     = CTRL_CW,
    parameter int CNTW   = 32
);

    logic [CW-1:0]        ctrl_d;
    logic                 valid_d;
    logic                 ready_d;
    logic [STAGES-1:0]    stall;
    logic [STAGES-1:0]    flush;
    logic                 exc;
    logic [STAGES*CW-1:0] ctrl_q;
    logic [STAGES-1:0]    valid_q;
    logic [CNTW-1:0]      bubble_cnt;

    modport master (
        output ctrl_d, valid_d, stall, flush, exc,
        input  ready_d, ctrl_q, valid_q, bubble_cnt
    );

    modport slave (
        input  ctrl_d, valid_d, stall, flush, exc,
        output ready_d, ctrl_q, valid_q, bubble_cnt
    );

endinterface

// File: rtl/ctrl_stage.sv
// ctrl_stage: one control-pipeline register with its next-state mux.
//   clk, rst             clock, synchronous active-high reset
//   src_ctrl, src_valid  bundle offered by the previous stage (or decode)
//   hold                 keep current contents (effective stall of this stage)
//   clr                  flush: empty the stage, wins over hold
//   bub                  previous stage is frozen: load a bubble instead
//   kill, mask           on load, clear the bits selected by mask
//   ctrl, valid          registered bundle and valid
module ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int CW = CTRL_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] src_ctrl,
    input  logic          src_valid,
    input  logic          hold,
    input  logic          clr,
    input  logic          bub,
    input  logic          kill,
    input  logic [CW-1:0] mask,
    output logic [CW-1:0] ctrl,
    output logic          valid
);

    logic [CW-1:0] ctrl_q, ctrl_d;
    logic          valid_q, valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (clr) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (hold) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else if (bub) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else begin
            // Squash keeps valid: the instruction retires with its writes masked off.
            ctrl_d  = kill ? (src_ctrl & ~mask) : src_ctrl;
            valid_d = src_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl  = ctrl_q;
    assign valid = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: parametrised control-signal pipeline from decode through STAGES stages.
//   clk, rst  clock, synchronous active-high reset
//   bus       ctrl_pipe_if.slave: ctrl_d/valid_d/ready_d from decode, per-stage
//             stall/flush, exc squash, per-stage ctrl_q/valid_q, bubble_cnt
// Stage 0 is E; the last stage is writeback. An older stage's stall freezes every
// younger stage, and the stage just behind a frozen one receives bubbles.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int CW        = CTRL_CW,
    parameter int EXC_STAGE = 0,
    parameter     KILL_MASK = KILL_MASK_REGWRITE,
    parameter int CNTW      = 32
) (
    input  logic         clk,
    input  logic         rst,
    ctrl_pipe_if.slave   bus
);

    localparam int LAST = STAGES - 1;

    if (STAGES < 2) begin : g_bad_stages
        $error("ctrl_pipe: STAGES must be >= 2");
    end
    if (EXC_STAGE < 0 || EXC_STAGE > STAGES - 2) begin : g_bad_exc_stage
        $error("ctrl_pipe: EXC_STAGE must be in 0..STAGES-2");
    end
    if ($bits(KILL_MASK) != CW) begin : g_bad_kill_mask
        $error("ctrl_pipe: KILL_MASK width must equal CW");
    end

    logic [STAGES-1:0] stall_eff;

    for (genvar k = 0; k < STAGES; k++) begin : g_stall_eff
        assign stall_eff[k] = |bus.stall[STAGES-1:k];
    end

    assign bus.ready_d = ~stall_eff[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CW-1:0] src_ctrl;
        logic          src_valid;
        logic          bub;
        logic          kill;

        if (k == 0) begin : g_first
            assign src_ctrl  = bus.ctrl_d;
            assign src_valid = bus.valid_d;
            assign bub       = 1'b0;
        end else begin : g_rest
            assign src_ctrl  = bus.ctrl_q[(k-1)*CW +: CW];
            assign src_valid = bus.valid_q[k-1];
            assign bub       = stall_eff[k-1];
        end

        // Only the stage that loads from EXC_STAGE applies the squash; when it is
        // holding, the load does not happen and exc is dropped.
        assign kill = (k == EXC_STAGE + 1) ? bus.exc : 1'b0;

        ctrl_stage #(
            .CW (CW)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .src_ctrl  (src_ctrl),
            .src_valid (src_valid),
            .hold      (stall_eff[k]),
            .clr       (bus.flush[k]),
            .bub       (bub),
            .kill      (kill),
            .mask      (KILL_MASK),
            .ctrl      (bus.ctrl_q[k*CW +: CW]),
            .valid     (bus.valid_q[k])
        );
    end

    logic            valid_last_d;
    logic [CNTW-1:0] bubble_cnt_q, bubble_cnt_d;

    // The counter reflects the writeback valid as it will be after this edge,
    // so the next-state of the last stage's valid is rebuilt here.
    always_comb begin
        valid_last_d = bus.valid_q[LAST-1];
        if (bus.flush[LAST]) begin
            valid_last_d = 1'b0;
        end else if (stall_eff[LAST]) begin
            valid_last_d = bus.valid_q[LAST];
        end else if (stall_eff[LAST-1]) begin
            valid_last_d = 1'b0;
        end

        bubble_cnt_d = bubble_cnt_q;
        if (!valid_last_d && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;

endmodule
